// File: rtl/cascade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_pkg
//  Description : Shared types and helpers for Haar cascade stage loading:
//                load FSM states, words-per-stage and stage base address.
//  Revision    : 1.0 - initial release
// ============================================================================
package cascade_pkg;

    localparam int DEF_NUM_CLASSIFIERS          = 10;
    localparam int DEF_NUM_PARAM_PER_CLASSIFIER = 19;
    localparam int DEF_NUM_STAGE_THRESHOLD      = 3;

    // Stage load sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } load_state_t;

    // Number of contiguous ROM words holding one stage's parameters
    function automatic int words_per_stage(input int num_classifiers,
                                           input int num_param_per_classifier,
                                           input int num_stage_threshold);
        return num_classifiers * num_param_per_classifier + num_stage_threshold;
    endfunction

    // First ROM address of a stage's region
    function automatic int stage_base(input int stage, input int words);
        return stage * words;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first active
//                request strictly after the last granted index, wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SEL_WIDTH-1:0] last,
    output logic [NUM_REQ-1:0]   grant
);

    logic found;
    int   idx;

    // Scan from last+1 around the ring; the first requester found wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stage_load_arbiter
//  Description : Round-robin sequencer that streams each requesting stage's
//                contiguous parameter region out of a shared ROM into that
//                stage's register buffer, then pulses a per-stage done.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_load_arbiter
    import cascade_pkg::*;
#(
    parameter int NUM_STAGES               = 4,
    parameter int ADDR_WIDTH               = 10,
    parameter int DATA_WIDTH_16            = 16,
    parameter int NUM_CLASSIFIERS          = DEF_NUM_CLASSIFIERS,
    parameter int NUM_PARAM_PER_CLASSIFIER = DEF_NUM_PARAM_PER_CLASSIFIER,
    parameter int NUM_STAGE_THRESHOLD      = DEF_NUM_STAGE_THRESHOLD,
    parameter int STAGE_SEL_WIDTH          = 2
) (
    input  logic                       clk_fpga,
    input  logic                       reset_fpga,
    input  logic [NUM_STAGES-1:0]      i_req,
    output logic [NUM_STAGES-1:0]      o_grant,
    output logic                       o_busy,
    output logic                       o_rom_ren,
    output logic [ADDR_WIDTH-1:0]      o_rom_addr,
    input  logic [DATA_WIDTH_16-1:0]   i_rom_data,
    output logic                       o_wr_en,
    output logic [STAGE_SEL_WIDTH-1:0] o_wr_stage,
    output logic [ADDR_WIDTH-1:0]      o_wr_index,
    output logic [DATA_WIDTH_16-1:0]   o_wr_data,
    output logic [NUM_STAGES-1:0]      o_done
);

    localparam int WORDS = words_per_stage(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER,
                                           NUM_STAGE_THRESHOLD);
    localparam logic [ADDR_WIDTH-1:0]      LAST_CNT  = ADDR_WIDTH'(WORDS - 1);
    localparam logic [STAGE_SEL_WIDTH-1:0] LAST_INIT = STAGE_SEL_WIDTH'(NUM_STAGES - 1);

    // Parameter sanity: all stage regions must fit in the ROM address space
    if (NUM_STAGES < 2) begin : g_stages_err
        $error("stage_load_arbiter: NUM_STAGES must be at least 2");
    end
    if (STAGE_SEL_WIDTH != $clog2(NUM_STAGES)) begin : g_sel_err
        $error("stage_load_arbiter: STAGE_SEL_WIDTH must equal clog2(NUM_STAGES)");
    end
    if (NUM_STAGES * WORDS > (1 << ADDR_WIDTH)) begin : g_addr_err
        $error("stage_load_arbiter: stage regions exceed ROM address space");
    end

    load_state_t                state, state_nxt;
    logic [NUM_STAGES-1:0]      grant, grant_nxt;
    logic [STAGE_SEL_WIDTH-1:0] sel, sel_nxt;
    logic [STAGE_SEL_WIDTH-1:0] last, last_nxt;
    logic [ADDR_WIDTH-1:0]      cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]      cnt_inc;
    logic                       rom_ren, rom_ren_nxt;
    logic [ADDR_WIDTH-1:0]      rom_addr, rom_addr_nxt;
    logic                       busy, busy_nxt;
    logic [NUM_STAGES-1:0]      done, done_nxt;
    logic                       wr_en;
    logic [ADDR_WIDTH-1:0]      wr_index;
    logic [NUM_STAGES-1:0]      arb_grant;
    logic [STAGE_SEL_WIDTH-1:0] arb_sel;
    logic [ADDR_WIDTH:0]        first_sum;
    logic [ADDR_WIDTH:0]        next_sum;

    rr_arbiter #(
        .NUM_REQ   (NUM_STAGES),
        .SEL_WIDTH (STAGE_SEL_WIDTH)
    ) u_rr_arbiter (
        .req   (i_req),
        .last  (last),
        .grant (arb_grant)
    );

    // Encode the one-hot arbiter result into a stage index
    always_comb begin
        arb_sel = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (arb_grant[i]) begin
                arb_sel = STAGE_SEL_WIDTH'(i);
            end
        end
    end

    // Addresses are formed one bit wider and truncated; range is guaranteed above
    assign cnt_inc   = cnt + 1'b1;
    assign first_sum = (ADDR_WIDTH+1)'(stage_base(int'(arb_sel), WORDS));
    assign next_sum  = (ADDR_WIDTH+1)'(stage_base(int'(sel), WORDS)) + {1'b0, cnt_inc};

    // Load state register
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        sel_nxt      = sel;
        last_nxt     = last;
        cnt_nxt      = cnt;
        rom_ren_nxt  = 1'b0;
        rom_addr_nxt = rom_addr;
        busy_nxt     = busy;
        done_nxt     = '0;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    grant_nxt    = arb_grant;
                    sel_nxt      = arb_sel;
                    cnt_nxt      = '0;
                    busy_nxt     = 1'b1;
                    rom_ren_nxt  = 1'b1;
                    rom_addr_nxt = first_sum[ADDR_WIDTH-1:0];
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt      = cnt_inc;
                    rom_ren_nxt  = 1'b1;
                    rom_addr_nxt = next_sum[ADDR_WIDTH-1:0];
                end
            end
            DRAIN: begin
                // Last data word is written this cycle; completion is signalled next
                done_nxt  = grant;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
                state_nxt = DONE;
            end
            DONE: begin
                last_nxt  = sel;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, round-robin pointer and word counter
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            grant    <= '0;
            sel      <= '0;
            last     <= LAST_INIT;
            cnt      <= '0;
            rom_ren  <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= '0;
        end else begin
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            rom_ren  <= rom_ren_nxt;
            rom_addr <= rom_addr_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Write strobe and index trail the ROM read by its one-cycle latency
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            wr_en    <= 1'b0;
            wr_index <= '0;
        end else begin
            wr_en    <= rom_ren;
            wr_index <= cnt;
        end
    end

    assign o_grant    = grant;
    assign o_busy     = busy;
    assign o_rom_ren  = rom_ren;
    assign o_rom_addr = rom_addr;
    assign o_wr_en    = wr_en;
    assign o_wr_stage = sel;
    assign o_wr_index = wr_index;
    assign o_wr_data  = i_rom_data;
    assign o_done     = done;

endmodule
`default_nettype wire

// File: tb/tb_stage_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_load_arbiter
//  Description : Scoreboard bench for stage_load_arbiter with a ROM model that
//                returns data equal to the address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_load_arbiter;

    localparam int NS    = 4;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int SW    = 2;
    localparam int WORDS = 193;

    logic           clk_fpga = 1'b0;
    logic           reset_fpga;
    logic [NS-1:0]  i_req;
    logic [NS-1:0]  o_grant;
    logic           o_busy;
    logic           o_rom_ren;
    logic [AW-1:0]  o_rom_addr;
    logic [DW-1:0]  i_rom_data = '0;
    logic           o_wr_en;
    logic [SW-1:0]  o_wr_stage;
    logic [AW-1:0]  o_wr_index;
    logic [DW-1:0]  o_wr_data;
    logic [NS-1:0]  o_done;

    stage_load_arbiter dut (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .i_req      (i_req),
        .o_grant    (o_grant),
        .o_busy     (o_busy),
        .o_rom_ren  (o_rom_ren),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .o_wr_en    (o_wr_en),
        .o_wr_stage (o_wr_stage),
        .o_wr_index (o_wr_index),
        .o_wr_data  (o_wr_data),
        .o_done     (o_done)
    );

    always #5 clk_fpga = ~clk_fpga;

    int cyc = 0;
    always @(posedge clk_fpga) cyc <= cyc + 1;

    // ROM model: one-cycle read latency, data equals address
    always @(posedge clk_fpga) begin
        if (o_rom_ren) i_rom_data <= DW'(o_rom_addr);
    end

    typedef struct { int stage; int index; int data; } wr_t;
    typedef struct { int stage; int at; } done_t;

    int    addr_q[$];
    wr_t   wr_q[$];
    done_t done_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected traffic of one complete load whose request is sampled at cycle t0
    task automatic push_load(input int stage, input int t0);
        for (int k = 0; k < WORDS; k++) begin
            addr_q.push_back(stage * WORDS + k);
            wr_q.push_back('{stage, k, stage * WORDS + k});
        end
        done_q.push_back('{stage, t0 + WORDS + 2});
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk_fpga);
    endtask

    task automatic reset_pulse();
        @(negedge clk_fpga);
        reset_fpga = 1'b1;
        @(negedge clk_fpga);
        reset_fpga = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},    int'(o_grant),    0);
        check({tag, "_busy"},     int'(o_busy),     0);
        check({tag, "_rom_ren"},  int'(o_rom_ren),  0);
        check({tag, "_rom_addr"}, int'(o_rom_addr), 0);
        check({tag, "_wr_en"},    int'(o_wr_en),    0);
        check({tag, "_wr_stage"}, int'(o_wr_stage), 0);
        check({tag, "_wr_index"}, int'(o_wr_index), 0);
        check({tag, "_done"},     int'(o_done),     0);
    endtask

    // Monitor: compares every DUT presentation against the scoreboard queues
    wr_t   mw;
    done_t md;
    int    ma;
    always @(negedge clk_fpga) begin
        if (!reset_fpga) begin
            check("grant_onehot0", int'($onehot0(o_grant)), 1);
            if (o_rom_ren) begin
                if (addr_q.size() == 0) check("rom_ren_unexpected", 1, 0);
                else begin
                    ma = addr_q.pop_front();
                    check("rom_addr", int'(o_rom_addr), ma);
                    check("busy_while_reading", int'(o_busy), 1);
                end
            end
            if (o_wr_en) begin
                if (wr_q.size() == 0) check("wr_en_unexpected", 1, 0);
                else begin
                    mw = wr_q.pop_front();
                    check("wr_stage", int'(o_wr_stage), mw.stage);
                    check("wr_index", int'(o_wr_index), mw.index);
                    check("wr_data",  int'(o_wr_data),  mw.data);
                    check("grant_during_write", int'(o_grant), 1 << mw.stage);
                end
            end
            if (o_done != '0) begin
                if (done_q.size() == 0) check("done_unexpected", int'(o_done), 0);
                else begin
                    md = done_q.pop_front();
                    check("done_vector", int'(o_done), 1 << md.stage);
                    check("done_cycle", cyc, md.at);
                    check("grant_at_done", int'(o_grant), 0);
                    check("busy_at_done", int'(o_busy), 0);
                end
            end
        end
    end

    int c;
    initial begin
        reset_fpga = 1'b1;
        i_req      = '0;
        repeat (3) @(negedge clk_fpga);
        check_reset_outputs("reset");
        @(negedge clk_fpga);
        reset_fpga = 1'b0;

        // Single one-cycle request from stage 2: addresses 386..578, done at +195
        @(negedge clk_fpga);
        c = cyc;
        i_req = 4'b0100;
        push_load(2, c);
        @(negedge clk_fpga);
        i_req = '0;
        goto(c + WORDS + 4);

        // Requests 0 and 3 held from reset: stage 0 first, then stage 3
        @(negedge clk_fpga);
        reset_fpga = 1'b1;
        i_req = 4'b1001;
        @(negedge clk_fpga);
        reset_fpga = 1'b0;
        c = cyc;
        push_load(0, c);
        push_load(3, c + WORDS + 3);
        goto(c + WORDS + 2);
        i_req[0] = 1'b0;
        goto(c + 2 * WORDS + 5);
        i_req[3] = 1'b0;
        goto(c + 2 * WORDS + 7);

        // All four held: grant order 0,1,2,3,0 with 196-cycle done spacing
        @(negedge clk_fpga);
        reset_fpga = 1'b1;
        i_req = 4'b1111;
        @(negedge clk_fpga);
        reset_fpga = 1'b0;
        c = cyc;
        push_load(0, c);
        push_load(1, c + 196);
        push_load(2, c + 2 * 196);
        push_load(3, c + 3 * 196);
        push_load(0, c + 4 * 196);
        goto(c + 4 * 196 + 1);
        i_req = '0;
        goto(c + 5 * 196 + 1);

        // Stage 1 drops its request at write index 40; load still completes
        reset_pulse();
        @(negedge clk_fpga);
        c = cyc;
        i_req = 4'b0010;
        push_load(1, c);
        goto(c + 42);
        check("drop_point_index", int'(o_wr_index), 40);
        i_req = '0;
        goto(c + WORDS + 4);

        // Reset at write index 50 of stage 2: outputs clear, no done, restart at 386
        reset_pulse();
        @(negedge clk_fpga);
        c = cyc;
        i_req = 4'b0100;
        push_load(2, c);
        @(negedge clk_fpga);
        i_req = '0;
        goto(c + 52);
        #2;
        check("abort_point_index", int'(o_wr_index), 50);
        reset_fpga = 1'b1;
        #1;
        check_reset_outputs("midload_reset");
        addr_q.delete();
        wr_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk_fpga);
        reset_fpga = 1'b0;
        repeat (4) @(negedge clk_fpga);
        c = cyc;
        i_req = 4'b0100;
        push_load(2, c);
        @(negedge clk_fpga);
        i_req = '0;
        goto(c + WORDS + 4);

        // Request raised during DRAIN is granted at cycle WORDS+4
        reset_pulse();
        @(negedge clk_fpga);
        c = cyc;
        i_req = 4'b0001;
        push_load(0, c);
        goto(c + WORDS + 1);
        i_req[1] = 1'b1;
        push_load(1, c + WORDS + 3);
        goto(c + WORDS + 2);
        i_req[0] = 1'b0;
        goto(c + WORDS + 3);
        check("grant_in_idle", int'(o_grant), 0);
        goto(c + WORDS + 4);
        check("drain_req_grant", int'(o_grant), 4'b0010);
        goto(c + 2 * WORDS + 5);
        i_req = '0;
        goto(c + 2 * WORDS + 8);

        check("addr_q_left", addr_q.size(), 0);
        check("wr_q_left",   wr_q.size(),   0);
        check("done_q_left", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
